// File: rtl/axi_lite_slave_bridge.sv
// -----------------------------------------------------------------------------
// axi_lite_slave_bridge
//
// Bridges an AXI4-Lite slave port onto a simple single-strobe peripheral
// handshake. It holds one outstanding read and one outstanding write.
//
// AR, AW and W are each captured into a one-entry holding register. A capture
// register frees up only when its R or B response handshake completes. When
// both a read and a write are pending, they are served round-robin. An address
// outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) is answered with DECERR and no
// peripheral strobe.
//
// Optional feature macro: AXI_SLV_TIMEOUT_EN
//   defined   - hs_ready_i wait is bounded by TIMEOUT_CYC cycles; expiry -> SLVERR
//   undefined - the bridge waits indefinitely for hs_ready_i
//
// Ports
//   clk_i, rst_i                      clock (rising edge), async active-low reset
//   arvalid_i/arready_o/araddr_i      AXI read address channel
//   rvalid_o/rready_i/rdata_o/rresp_o AXI read data channel
//   awvalid_i/awready_o/awaddr_i      AXI write address channel
//   wvalid_i/wready_o/wdata_i/wstrb_i AXI write data channel
//   bvalid_o/bready_i/bresp_o         AXI write response channel
//   hs_read_o/hs_write_o              peripheral strobes, held until hs_ready_i
//   hs_addr_o/hs_data_o               peripheral address / write data
//   hs_ready_i/hs_data_i              peripheral completion / read data
//   byte_select_o                     write strobes on writes, all ones on reads
// -----------------------------------------------------------------------------
module axi_lite_slave_bridge #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] ADDR_BASE   = '0,
  parameter logic [ADDR_W-1:0] ADDR_SIZE   = ADDR_W'('h1000),
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ADDR_W-1:0]     araddr_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [1:0]            rresp_o,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [ADDR_W-1:0]     awaddr_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic [1:0]            bresp_o,
  output logic                  hs_read_o,
  output logic                  hs_write_o,
  output logic [ADDR_W-1:0]     hs_addr_o,
  output logic [DATA_W-1:0]     hs_data_o,
  input  logic                  hs_ready_i,
  input  logic [DATA_W-1:0]     hs_data_i,
  output logic [DATA_W/8-1:0]   byte_select_o
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  if (!((DATA_W == 32) || (DATA_W == 64)) || (TIMEOUT_CYC < 1)) begin : g_cfg_err
    $error("axi_lite_slave_bridge: DATA_W must be 32 or 64 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DEC    = 3'd1,
    S_SLV_R  = 3'd2,
    S_SLV_W  = 3'd3,
    S_R_RESP = 3'd4,
    S_B_RESP = 3'd5
  } state_t;

  state_t state_q, state_d;

  // capture registers
  logic              ar_full_q, aw_full_q, w_full_q;
  logic              ar_full_d, aw_full_d, w_full_d;
  logic [ADDR_W-1:0] ar_addr_q, aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  logic ar_hs, aw_hs, w_hs;
  logic r_done, b_done;
  logic rd_pend, wr_pend, pick_wr;

  // sel_wr_q is both the side being served and the last side served, so it
  // doubles as the round-robin flag. Reset to "write" so reads go first.
  logic sel_wr_q;

  logic [ADDR_W-1:0] dec_addr, dec_off;
  logic              dec_hit;
  logic              to_hit;

  assign ar_hs  = arvalid_i && arready_o;
  assign aw_hs  = awvalid_i && awready_o;
  assign w_hs   = wvalid_i  && wready_o;
  assign r_done = (state_q == S_R_RESP) && rready_i;
  assign b_done = (state_q == S_B_RESP) && bready_i;

  assign rd_pend = ar_full_q;
  assign wr_pend = aw_full_q && w_full_q;
  assign pick_wr = wr_pend && (!rd_pend || !sel_wr_q);

  // Offset compare handles both below-base addresses (wrap to large) and
  // windows ending at the top of the address space.
  assign dec_addr = sel_wr_q ? aw_addr_q : ar_addr_q;
  assign dec_off  = dec_addr - ADDR_BASE;
  assign dec_hit  = (dec_off < ADDR_SIZE);

  always_comb begin
    ar_full_d = ar_full_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    if (ar_hs)  ar_full_d = 1'b1;
    if (aw_hs)  aw_full_d = 1'b1;
    if (w_hs)   w_full_d  = 1'b1;
    if (r_done) ar_full_d = 1'b0;
    if (b_done) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
  end

  // Control registers: capture flags, readies and round-robin flag.
  // Readies are registered copies of !full, so they rise one edge after reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ar_full_q <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      arready_o <= 1'b0;
      awready_o <= 1'b0;
      wready_o  <= 1'b0;
      sel_wr_q  <= 1'b1;
    end else begin
      ar_full_q <= ar_full_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      arready_o <= !ar_full_d;
      awready_o <= !aw_full_d;
      wready_o  <= !w_full_d;
      if ((state_q == S_IDLE) && (rd_pend || wr_pend)) sel_wr_q <= pick_wr;
    end
  end

  // Capture payloads; meaningful only while the matching full flag is set.
  always_ff @(posedge clk_i) begin
    if (ar_hs) ar_addr_q <= araddr_i;
    if (aw_hs) aw_addr_q <= awaddr_i;
    if (w_hs) begin
      w_data_q <= wdata_i;
      w_strb_q <= wstrb_i;
    end
  end

`ifdef AXI_SLV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt_q;

  // The counter restarts on every entry to a strobe state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      to_cnt_q <= '0;
    end else if (state_q == S_DEC) begin
      to_cnt_q <= '0;
    end else if ((state_q == S_SLV_R) || (state_q == S_SLV_W)) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign to_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (rd_pend || wr_pend) state_d = S_DEC;
      S_DEC: begin
        if (dec_hit) state_d = sel_wr_q ? S_SLV_W  : S_SLV_R;
        else         state_d = sel_wr_q ? S_B_RESP : S_R_RESP;
      end
      S_SLV_R:  if (hs_ready_i || to_hit) state_d = S_R_RESP;
      S_SLV_W:  if (hs_ready_i || to_hit) state_d = S_B_RESP;
      S_R_RESP: if (rready_i) state_d = S_IDLE;
      S_B_RESP: if (bready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    hs_read_o  = 1'b0;
    hs_write_o = 1'b0;
    rvalid_o   = 1'b0;
    bvalid_o   = 1'b0;
    case (state_q)
      S_SLV_R:  hs_read_o  = 1'b1;
      S_SLV_W:  hs_write_o = 1'b1;
      S_R_RESP: rvalid_o   = 1'b1;
      S_B_RESP: bvalid_o   = 1'b1;
      default:  ;
    endcase
  end

  // Peripheral request and response registers. Loaded only on the way into a
  // strobe or response state, so they hold while valids/strobes are up or low.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hs_addr_o     <= '0;
      hs_data_o     <= '0;
      byte_select_o <= '0;
      rdata_o       <= '0;
      rresp_o       <= RESP_OKAY;
      bresp_o       <= RESP_OKAY;
    end else begin
      case (state_q)
        S_DEC: begin
          if (dec_hit) begin
            hs_addr_o <= dec_addr;
            if (sel_wr_q) begin
              hs_data_o     <= w_data_q;
              byte_select_o <= w_strb_q;
            end else begin
              byte_select_o <= '1;
            end
          end else if (sel_wr_q) begin
            bresp_o <= RESP_DECERR;
          end else begin
            rdata_o <= '0;
            rresp_o <= RESP_DECERR;
          end
        end
        S_SLV_R: begin
          if (hs_ready_i) begin
            rdata_o <= hs_data_i;
            rresp_o <= RESP_OKAY;
          end else if (to_hit) begin
            rdata_o <= '0;
            rresp_o <= RESP_SLVERR;
          end
        end
        S_SLV_W: begin
          if (hs_ready_i)  bresp_o <= RESP_OKAY;
          else if (to_hit) bresp_o <= RESP_SLVERR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_bridge.sv
module tb_axi_lite_slave_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        arvalid_i = 1'b0, arready_o;
  logic [31:0] araddr_i = '0;
  logic        rvalid_o, rready_i = 1'b0;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        awvalid_i = 1'b0, awready_o;
  logic [31:0] awaddr_i = '0;
  logic        wvalid_i = 1'b0, wready_o;
  logic [31:0] wdata_i = '0;
  logic [3:0]  wstrb_i = '0;
  logic        bvalid_o, bready_i = 1'b0;
  logic [1:0]  bresp_o;
  logic        hs_read_o, hs_write_o;
  logic [31:0] hs_addr_o, hs_data_o;
  logic        hs_ready_i = 1'b0;
  logic [31:0] hs_data_i = '0;
  logic [3:0]  byte_select_o;

  axi_lite_slave_bridge #(
    .ADDR_W(32), .DATA_W(32), .ADDR_BASE(32'h0), .ADDR_SIZE(32'h1000), .TIMEOUT_CYC(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
    .hs_read_o(hs_read_o), .hs_write_o(hs_write_o), .hs_addr_o(hs_addr_o),
    .hs_data_o(hs_data_o), .hs_ready_i(hs_ready_i), .hs_data_i(hs_data_i),
    .byte_select_o(byte_select_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- peripheral model ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  bsel;
  } hs_t;

  hs_t         hs_log[$];
  logic [31:0] periph_data = '0;
  int          periph_dly = 0;
  int          strobe_cnt = 0;
  int          strobe_cycles = 0;
  int          excl_err = 0;

  always @(negedge clk_i) begin
    hs_t e;
    if (hs_read_o && hs_write_o) excl_err++;
    if (hs_read_o || hs_write_o) begin
      strobe_cycles++;
      if (strobe_cnt == periph_dly) begin
        hs_ready_i = 1'b1;
        hs_data_i  = periph_data;
        e.wr = hs_write_o; e.addr = hs_addr_o; e.data = hs_data_o; e.bsel = byte_select_o;
        hs_log.push_back(e);
      end else begin
        hs_ready_i = 1'b0;
        hs_data_i  = ~periph_data;
      end
      strobe_cnt++;
    end else begin
      hs_ready_i = 1'b0;
      hs_data_i  = ~periph_data;
      strobe_cnt = 0;
    end
  end

  // ---------------- reference model ----------------
  bit last_wr = 1'b1;  // last side served; after reset reads go first

  function automatic bit in_win(input logic [31:0] a);
    return (a < 32'h1000);
  endfunction

  // ---------------- master tasks ----------------
  task automatic issue(input bit ar, input logic [31:0] ra, input bit aw, input logic [31:0] wa,
                       input bit w, input logic [31:0] wd, input logic [3:0] ws);
    int n = 0;
    bit a1, a2, a3;
    arvalid_i = ar; araddr_i = ra;
    awvalid_i = aw; awaddr_i = wa;
    wvalid_i  = w;  wdata_i  = wd; wstrb_i = ws;
    while ((arvalid_i || awvalid_i || wvalid_i) && n < 100) begin
      a1 = arvalid_i && arready_o;
      a2 = awvalid_i && awready_o;
      a3 = wvalid_i  && wready_o;
      @(negedge clk_i);
      if (a1) arvalid_i = 1'b0;
      if (a2) awvalid_i = 1'b0;
      if (a3) wvalid_i  = 1'b0;
      n++;
    end
    if (arvalid_i || awvalid_i || wvalid_i) begin
      check("issue_accept", {arvalid_i, awvalid_i, wvalid_i}, 3'b000);
      arvalid_i = 1'b0; awvalid_i = 1'b0; wvalid_i = 1'b0;
    end
  endtask

  task automatic collect_r(input logic [31:0] ed, input logic [1:0] er, input int stall, input string tag);
    int n = 0;
    logic [31:0] d0;
    logic [1:0]  r0;
    while (!rvalid_o && n < 100) begin @(negedge clk_i); n++; end
    check({tag, "_rvalid"}, rvalid_o, 1'b1);
    if (!rvalid_o) return;
    d0 = rdata_o; r0 = rresp_o;
    repeat (stall) @(negedge clk_i);
    if (stall > 0) check({tag, "_r_hold"}, {rvalid_o, rdata_o, rresp_o}, {1'b1, d0, r0});
    check({tag, "_rdata"}, rdata_o, ed);
    check({tag, "_rresp"}, rresp_o, er);
    rready_i = 1'b1;
    @(negedge clk_i);
    rready_i = 1'b0;
    check({tag, "_rvalid_drop"}, rvalid_o, 1'b0);
  endtask

  task automatic collect_b(input logic [1:0] er, input int stall, input string tag);
    int n = 0;
    logic [1:0] r0;
    while (!bvalid_o && n < 100) begin @(negedge clk_i); n++; end
    check({tag, "_bvalid"}, bvalid_o, 1'b1);
    if (!bvalid_o) return;
    r0 = bresp_o;
    repeat (stall) @(negedge clk_i);
    if (stall > 0) check({tag, "_b_hold"}, {bvalid_o, bresp_o}, {1'b1, r0});
    check({tag, "_bresp"}, bresp_o, er);
    bready_i = 1'b1;
    @(negedge clk_i);
    bready_i = 1'b0;
    check({tag, "_bvalid_drop"}, bvalid_o, 1'b0);
  endtask

  task automatic check_hs(input bit present, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] bs, input string tag);
    hs_t e;
    check({tag, "_hs_count"}, hs_log.size(), present);
    if (present && hs_log.size() > 0) begin
      e = hs_log.pop_front();
      if (wr) check({tag, "_hs_wr"}, {e.wr, e.addr, e.data, e.bsel}, {1'b1, a, d, bs});
      else    check({tag, "_hs_rd"}, {e.wr, e.addr, e.bsel}, {1'b0, a, 4'hF});
    end
    hs_log.delete();
  endtask

  // One read and/or one write issued together; served in round-robin order.
  task automatic txn(input bit do_rd, input bit do_wr, input logic [31:0] ra, input logic [31:0] wa,
                     input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd_val,
                     input int dly, input int stall, input string tag);
    int  s0, exp_cyc, nsides;
    bit  first_wr, side_wr;
    periph_dly  = dly;
    periph_data = rd_val;
    s0 = strobe_cycles;
    exp_cyc = 0;
    issue(do_rd, ra, do_wr, wa, do_wr, wd, ws);
    first_wr = do_wr && !(do_rd && last_wr);
    nsides = int'(do_rd) + int'(do_wr);
    for (int k = 0; k < nsides; k++) begin
      side_wr = (k == 0) ? first_wr : !first_wr;
      if (side_wr) begin
        if (in_win(wa)) begin
          collect_b(2'b00, stall, tag);
          check_hs(1'b1, 1'b1, wa, wd, ws, tag);
          exp_cyc += dly + 1;
        end else begin
          collect_b(2'b11, stall, tag);
          check_hs(1'b0, 1'b1, wa, wd, ws, tag);
        end
      end else begin
        if (in_win(ra)) begin
          collect_r(rd_val, 2'b00, stall, tag);
          check_hs(1'b1, 1'b0, ra, '0, 4'hF, tag);
          exp_cyc += dly + 1;
        end else begin
          collect_r(32'h0, 2'b11, stall, tag);
          check_hs(1'b0, 1'b0, ra, '0, 4'hF, tag);
        end
      end
      last_wr = side_wr;
    end
    check({tag, "_strobe_cycles"}, strobe_cycles - s0, exp_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] ra, wa;

    // reset: everything low while asserted, readies rise one edge after release
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_outputs", {arready_o, awready_o, wready_o, rvalid_o, rdata_o, rresp_o, bvalid_o, bresp_o,
                            hs_read_o, hs_write_o, hs_addr_o, hs_data_o, byte_select_o}, '0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    check("ready_before_edge", {arready_o, awready_o, wready_o}, 3'b000);
    @(negedge clk_i);
    check("ready_after_edge", {arready_o, awready_o, wready_o}, 3'b111);

    // single read, peripheral answers one cycle after strobe
    txn(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF, 1, 0, "rd_deadbeef");

    // W arrives three cycles before AW
    periph_dly = 0;
    issue(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_55AA, 4'b0011);
    repeat (3) @(negedge clk_i);
    check("w_only_no_strobe", {hs_write_o, bvalid_o, 1'(hs_log.size() != 0)}, 3'b000);
    issue(1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 32'h0, 4'h0);
    collect_b(2'b00, 0, "w_before_aw");
    check_hs(1'b1, 1'b1, 32'h20, 32'h0000_55AA, 4'b0011, "w_before_aw");
    last_wr = 1'b1;

    // simultaneous read+write twice: read, write, read, write
    txn(1'b1, 1'b1, 32'h4, 32'h8, 32'h1111_2222, 4'hF, 32'hA5A5_0001, 0, 0, "rr_a");
    txn(1'b1, 1'b1, 32'h4, 32'h8, 32'h3333_4444, 4'h5, 32'hA5A5_0002, 0, 0, "rr_b");

    // out-of-window read -> DECERR, no strobe
    txn(1'b1, 1'b0, 32'h2000, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 0, "rd_decerr");

    // rready held low five cycles
    txn(1'b1, 1'b0, 32'h44, 32'h0, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 5, "rd_stall");

    // latency with zero-wait peripheral: handshake edge N, strobe N+2, rvalid N+3
    periph_dly = 0;
    periph_data = 32'h1234_5678;
    check("lat_arready", arready_o, 1'b1);
    arvalid_i = 1'b1; araddr_i = 32'h30;
    @(negedge clk_i);
    arvalid_i = 1'b0;
    check("lat_n0_strobe", hs_read_o, 1'b0);
    @(negedge clk_i);
    check("lat_n1_strobe", hs_read_o, 1'b0);
    @(negedge clk_i);
    check("lat_n2_strobe", hs_read_o, 1'b1);
    @(negedge clk_i);
    check("lat_n3_rvalid", rvalid_o, 1'b1);
    collect_r(32'h1234_5678, 2'b00, 0, "lat");
    check_hs(1'b1, 1'b0, 32'h30, '0, 4'hF, "lat");
    last_wr = 1'b0;

    // randomized mix
    for (int i = 0; i < 24; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      ra = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1000) : (32'($urandom_range(0, 32'hFFF)) & ~32'h3);
      wa = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1000) : (32'($urandom_range(0, 32'hFFF)) & ~32'h3);
      txn(kind != 1, kind != 0, ra, wa, $urandom, 4'($urandom_range(0, 15)), $urandom,
          $urandom_range(0, 3), $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

`ifdef AXI_SLV_TIMEOUT_EN
    // peripheral never answers: SLVERR after 8 strobe cycles
    begin
      int s0;
      periph_dly = 100000;
      s0 = strobe_cycles;
      issue(1'b0, 32'h0, 1'b1, 32'h50, 1'b1, 32'h7777_8888, 4'hF);
      collect_b(2'b10, 0, "timeout");
      check("timeout_strobe_cycles", strobe_cycles - s0, 8);
      check_hs(1'b0, 1'b1, 32'h50, 32'h0, 4'h0, "timeout");
      last_wr = 1'b1;
    end
`endif

    // reset asserted during a write strobe clears outputs immediately
    periph_dly = 100000;
    issue(1'b0, 32'h0, 1'b1, 32'h60, 1'b1, 32'h9999_AAAA, 4'hC);
    n = 0;
    while (!hs_write_o && n < 50) begin @(negedge clk_i); n++; end
    check("abort_strobe_seen", hs_write_o, 1'b1);
    rst_i = 1'b0;
    #1;
    check("abort_outputs", {arready_o, awready_o, wready_o, rvalid_o, rdata_o, rresp_o, bvalid_o, bresp_o,
                            hs_read_o, hs_write_o, hs_addr_o, hs_data_o, byte_select_o}, '0);
    @(negedge clk_i);
    rst_i = 1'b1;
    hs_log.delete();
    last_wr = 1'b1;
    periph_dly = 0;
    @(negedge clk_i);
    check("abort_ready", {arready_o, awready_o, wready_o}, 3'b111);
    repeat (3) @(negedge clk_i);
    check("abort_no_resp", {bvalid_o, rvalid_o, hs_write_o}, 3'b000);

    // bridge still works after the abort
    txn(1'b1, 1'b1, 32'h70, 32'h74, 32'h0F0F_0F0F, 4'h9, 32'h5A5A_5A5A, 1, 1, "post_abort");

    check("strobe_exclusive", excl_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
